// File: rtl/add_pipe_pkg.sv
// Shared defaults and helpers for the chunked pipelined adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package add_pipe_pkg;

    localparam int ADD_PIPE_WIDTH_DEF = 32;
    localparam int ADD_PIPE_CHUNK_DEF = 8;

    // Number of pipeline stages: one chunk of the operands is added per stage.
    function automatic int add_pipe_stages(input int width, input int chunk_w);
        return width / chunk_w;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK_W-bit adder slice with carry in/out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage owns flow control.
// Ports: a, b, ci -> s (CHUNK_W bits), co (carry out of the slice MSB).
module add_chunk #(
    parameter int CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               ci,
    output logic [CHUNK_W-1:0] s,
    output logic               co
);

    logic [CHUNK_W:0] sum_full;

    always_comb begin
        sum_full = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, ci};
        s        = sum_full[CHUNK_W-1:0];
        co       = sum_full[CHUNK_W];
    end

endmodule

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit add/sub; chunk k of the operands is summed in stage k.
// Latency: STAGES cycles from accepted beat to out_valid with out_ready high.
// Backpressure: whole pipe freezes when out_valid && !out_ready; in_ready = advance.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with in_a, in_b,
//        in_ci, in_sub; out_valid/out_ready with out_sum, out_co and, when
//        ADD_PIPE_OVF_EN is defined, out_ovf (signed overflow).
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH   = ADD_PIPE_WIDTH_DEF,
    parameter int CHUNK_W = ADD_PIPE_CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co
`ifdef ADD_PIPE_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int STAGES = add_pipe_stages(WIDTH, CHUNK_W);
    localparam int LAST   = STAGES - 1;

    if (((WIDTH % CHUNK_W) != 0) || (CHUNK_W > WIDTH)) begin : g_bad_cfg
        $error("add_pipe: WIDTH must be a non-zero multiple of CHUNK_W");
    end

    logic adv;

    // Stage registers. a/b travel whole so each stage can pick its own chunk;
    // s accumulates finished low chunks so the full sum exits together.
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];

    // Inputs seen by each stage's adder slice.
    logic [STAGES-1:0] src_vld, src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];

    logic [CHUNK_W-1:0] chunk_s [STAGES];
    logic [STAGES-1:0]  chunk_co;

    assign adv      = !vld_q[LAST] || out_ready;
    assign in_ready = adv;

    // Subtract is folded into stage 0: A + ~B with the carry-in forced to 1.
    always_comb begin
        src_vld = '0;
        src_c   = '0;
        src_a   = '{default: '0};
        src_b   = '{default: '0};
        src_s   = '{default: '0};
        src_vld[0] = in_valid;
        src_a[0]   = in_a;
        src_b[0]   = in_sub ? ~in_b : in_b;
        src_c[0]   = in_sub ? 1'b1 : in_ci;
        for (int k = 1; k < STAGES; k++) begin
            src_vld[k] = vld_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_s[k]   = s_q[k-1];
            src_c[k]   = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_chunk #(
            .CHUNK_W (CHUNK_W)
        ) u_chunk (
            .a  (src_a[k][k*CHUNK_W +: CHUNK_W]),
            .b  (src_b[k][k*CHUNK_W +: CHUNK_W]),
            .ci (src_c[k]),
            .s  (chunk_s[k]),
            .co (chunk_co[k])
        );
    end

    always_comb begin
        vld_d = vld_q;
        c_d   = c_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_d[k] = src_vld[k];
                a_d[k]   = src_a[k];
                b_d[k]   = src_b[k];
                s_d[k]   = src_s[k];
                s_d[k][k*CHUNK_W +: CHUNK_W] = chunk_s[k];
                c_d[k]   = chunk_co[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            c_q   <= c_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_sum   = s_q[LAST];
    assign out_co    = c_q[LAST];

`ifdef ADD_PIPE_OVF_EN
    // Signed overflow: operands (B already inverted for sub) share a sign
    // that differs from the result sign; equals carry-into-MSB ^ carry-out.
    logic ovf_d, ovf_q;

    always_comb begin
        ovf_d = ovf_q;
        if (adv) begin
            ovf_d = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
                    (chunk_s[LAST][CHUNK_W-1] != src_a[LAST][WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe at WIDTH=32, CHUNK_W=8 (four stages).
// Latency: checks result appears exactly four cycles after the input cycle.
// Backpressure: exercises out_ready toggling and stall stability.
module tb_add_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_ci;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_co;
`ifdef ADD_PIPE_OVF_EN
    logic        out_ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    add_pipe #(
        .WIDTH   (32),
        .CHUNK_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co)
`ifdef ADD_PIPE_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat into an empty pipe with out_ready high.
    task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic sub, input logic [31:0] es,
                            input logic eco, input logic eovf);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_ci    = ci;
        in_sub   = sub;
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk({tag, "_early_valid"}, out_valid, 1'b0);
            step();
        end
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_sum"}, out_sum, es);
        chk({tag, "_co"}, out_co, eco);
`ifdef ADD_PIPE_OVF_EN
        chk({tag, "_ovf"}, out_ovf, eovf);
`else
        if (eovf === 1'bx) $display("note: unexpected x in expected overflow");
`endif
    endtask

    logic [31:0] sa   [8];
    logic [31:0] sb   [8];
    logic        sci  [8];
    logic        ssub [8];
    logic [31:0] es   [8];
    logic        eco  [8];
    logic [32:0] model;
    int          idx;
    int          oidx;
    logic        prev_stall;
    logic [31:0] prev_sum;
    logic        prev_co;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_ci     = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_out_co", out_co, 1'b0);
`ifdef ADD_PIPE_OVF_EN
        chk("rst_out_ovf", out_ovf, 1'b0);
`endif
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Directed single beats
        send_one("add_1_2",    32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
        step();
        chk("no_dup_after_add", out_valid, 1'b0);
        send_one("ripple_ci",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send_one("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_one("sub_ci_ign", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_one("sub_min_1",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send_one("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_one("neg_neg",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        step();

        // Streaming with out_ready toggling 1,0,1,0...
        for (int i = 0; i < 8; i++) begin
            sa[i]   = $urandom;
            sb[i]   = $urandom;
            sci[i]  = 1'($urandom_range(0, 1));
            ssub[i] = 1'($urandom_range(0, 1));
            if (ssub[i]) model = {1'b0, sa[i]} + {1'b0, ~sb[i]} + 33'd1;
            else         model = {1'b0, sa[i]} + {1'b0, sb[i]} + {32'd0, sci[i]};
            es[i]  = model[31:0];
            eco[i] = model[32];
        end
        idx        = 0;
        oidx       = 0;
        prev_stall = 1'b0;
        prev_sum   = '0;
        prev_co    = 1'b0;
        for (int cyc = 0; cyc < 100 && oidx < 8; cyc++) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (idx < 8);
            if (idx < 8) begin
                in_a   = sa[idx];
                in_b   = sb[idx];
                in_ci  = sci[idx];
                in_sub = ssub[idx];
            end
            #1;
            chk("stream_in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                chk("stream_sum", out_sum, es[oidx]);
                chk("stream_co", out_co, eco[oidx]);
                oidx++;
            end
            if (in_valid && in_ready) idx++;
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
            prev_co    = out_co;
            step();
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_sum", out_sum, prev_sum);
                chk("stall_co", out_co, prev_co);
            end
        end
        chk("stream_count", oidx, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stream_no_extra", out_valid, 1'b0);
        end

        // Reset in mid-flight
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_a     = 32'(i);
            in_b     = 32'(i);
            in_ci    = 1'b0;
            in_sub   = 1'b0;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_sum", out_sum, 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_sum", out_sum, 32'h0);
        chk("mid_rst_co", out_co, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_stale", out_valid, 1'b0);
        end
        chk("rel_in_ready", in_ready, 1'b1);
        send_one("post_rst", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0);
        step();
        chk("post_rst_no_dup", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK_W, default 8: bits added per pipeline stage; STAGES = WIDTH/CHUNK_W.
REQ-003 SHALL have port clk  input  1  the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted this cycle when in_valid is also high.
REQ-007 SHALL have port in_a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 SHALL have port in_b  input  WIDTH  operand B.
REQ-009 SHALL have port in_ci  input  1  carry-in (add mode only).
REQ-010 SHALL have port in_sub  input  1  1 = subtract A-B, 0 = add A+B+ci.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result beat.
REQ-013 SHALL have port out_sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 SHALL have port out_co  output  1  carry-out of MSB (sub: 1 = no borrow).
REQ-015 SHALL have port out_ovf  output  1  signed overflow; present only with ADD_PIPE_OVF_EN.

Function
REQ-016 SHALL compute add as A+B+in_ci and sub as A+~B+1, in_ci ignored when in_sub=1.
REQ-017 SHALL process chunk k (bits k*CHUNK_W..) in stage k; carry propagates stage k to k+1 via a register, lower chunks of the sum are delayed alongside so the full result exits together.
REQ-018 SHALL have latency exactly STAGES cycles from accepted input to out_valid when out_ready is held high.
REQ-019 SHALL sustain one accepted beat per cycle when out_ready is held high.
REQ-020 SHALL advance the whole pipeline only when advance = !out_valid | out_ready; in_ready SHALL equal advance.
REQ-021 SHALL hold out_sum, out_co, out_ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL propagate bubbles (per-stage valid bits); a bubble never raises out_valid.
REQ-023 SHALL deliver results in acceptance order, none dropped or duplicated under any stall pattern.
REQ-024 SHALL accept in_valid=1 with in_ready=0 without sampling operands.
REQ-025 SHALL handle full carry ripple across all chunks (e.g. all-ones + 1) correctly at STAGES latency.

Reset
REQ-026 SHALL on rst_n low clear all stage valid bits immediately; out_valid=0, out_sum=0, out_co=0, out_ovf=0.
REQ-027 SHALL discard in-flight beats on reset mid-operation; first post-reset result corresponds to first post-reset accepted beat.
REQ-028 SHALL drive in_ready=1 from the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with ADD_PIPE_OVF_EN defined, provide out_ovf = carry-into-MSB XOR carry-out-of-MSB, aligned with out_sum.
REQ-030 SHALL, without ADD_PIPE_OVF_EN, omit the out_ovf port and its logic; all other behaviour identical.

Structure
REQ-031 SHALL place defaults (ADD_PIPE_WIDTH_DEF=32, ADD_PIPE_CHUNK_DEF=8) and a STAGES helper function in package add_pipe_pkg.
REQ-032 SHALL instantiate sub-module add_chunk (CHUNK_W-bit combinational adder: a, b, ci -> s, co) once per stage via generate.
REQ-033 SHALL elaborate-time error if WIDTH mod CHUNK_W != 0 or CHUNK_W > WIDTH.

Verification (WIDTH=32, CHUNK_W=8, STAGES=4)
REQ-034 Add 0x0000_0001 + 0x0000_0002, ci=0, out_ready=1 -> out_valid exactly 4 cycles later, sum 0x0000_0003, co=0.
REQ-035 Add 0xFFFF_FFFF + 0x0000_0000, ci=1 -> sum 0x0000_0000, co=1; with OVF_EN ovf=0.
REQ-036 Sub 0x0000_0005 - 0x0000_0007 -> sum 0xFFFF_FFFE, co=0; sub 0x8000_0000 - 0x0000_0001 -> sum 0x7FFF_FFFF, co=1, ovf=1.
REQ-037 Stream 8 back-to-back random beats, out_ready toggling 1010..., -> 8 results in order matching reference model, outputs stable during stalls, in_ready low exactly when out_valid=1 and out_ready=0.
REQ-038 Accept 3 beats, assert rst_n=0 for 1 cycle mid-flight -> out_valid=0 immediately, no stale result after release; next beat 0x10+0x20 -> 0x30 at 4-cycle latency.
